score_display_ctrl: RTL and testbench

- Sequencing controller for the four-digit score readout on HEX3..HEX0.
- Accepts a binary score over a valid/ready handshake and converts it to BCD with a multi-cycle shift-add-3 (double-dabble) engine.
- Holds the four BCD digits in registers and feeds them to four hex7seg decoders.
- Adds leading-zero blanking and a game-over blink, so the game FSM only pushes raw scores.

---
 rtl/score_pkg.sv | 19 +
 rtl/hex7seg.sv | 30 +++
 rtl/score_display_ctrl.sv | 132 +++++++++++++
 tb/tb_score_display_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score readout: FSM encoding, segment
// constants and the double-dabble nibble correction.
package score_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_LOAD    = 2'd2
    } state_t;

    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam int unsigned SCORE_MAX = 9999;

    // Shift-add-3 correction applied to each BCD nibble before every shift.
    function automatic logic [3:0] dd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex digit to active-low seven-segment pattern, segment order {a,b,c,d,e,f,g}.
module hex7seg (
    input  logic [3:0] hex,
    output logic [0:6] display
);

    always_comb begin
        display = 7'b1111111;
        case (hex)
            4'h0: display = 7'b0000001;
            4'h1: display = 7'b1001111;
            4'h2: display = 7'b0010010;
            4'h3: display = 7'b0000110;
            4'h4: display = 7'b1001100;
            4'h5: display = 7'b0100100;
            4'h6: display = 7'b0100000;
            4'h7: display = 7'b0001111;
            4'h8: display = 7'b0000000;
            4'h9: display = 7'b0000100;
            4'hA: display = 7'b0001000;
            4'hB: display = 7'b1100000;
            4'hC: display = 7'b0110001;
            4'hD: display = 7'b1000010;
            4'hE: display = 7'b0110000;
            4'hF: display = 7'b0111000;
            default: display = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Four-digit score readout: binary score in, multi-cycle BCD conversion,
// registered digits, leading-zero blanking and game-over blink on HEX3..HEX0.
module score_display_ctrl
    import score_pkg::*;
#(
    parameter int SCORE_W   = 14,
    parameter int BLINK_DIV = 25000000,
    parameter int LZ_BLANK  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               score_valid,
    input  logic [SCORE_W-1:0] score,
    output logic               ready,
    input  logic               game_over,
    output logic [15:0]        digits,
    output logic [0:6]         HEX0,
    output logic [0:6]         HEX1,
    output logic [0:6]         HEX2,
    output logic [0:6]         HEX3,
    output logic [1:0]         state_dbg
);

    localparam int SR_W = 16 + SCORE_W;
    localparam int CW   = $clog2(SCORE_W + 1);
    localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] ITER_LAST  = CW'(SCORE_W - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    state_t             state, state_nxt;
    logic [SR_W-1:0]    sr, sr_adj, sr_step;
    logic [CW-1:0]      iter;
    logic [SCORE_W-1:0] score_sat;
    logic [BW-1:0]      blink_cnt;
    logic               blink_off;

    assign state_dbg = state;

    // Handshake: a transfer happens on a rising edge where score_valid & ready
    // are both high; score is sampled only then. ready is high only in IDLE and
    // offers made while it is low are dropped, never queued.
    assign score_sat = (32'(score) > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : score;

    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < 4; i++)
            sr_adj[SCORE_W + 4*i +: 4] = dd_adj(sr[SCORE_W + 4*i +: 4]);
    end

    assign sr_step = {sr_adj[SR_W-2:0], 1'b0};

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (score_valid)
                    state_nxt = S_CONVERT;
            end
            S_CONVERT: begin
                if (iter == ITER_LAST)
                    state_nxt = S_LOAD;
            end
            S_LOAD:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // digits are only written in LOAD, so the display never shows partial sums.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr     <= '0;
            iter   <= '0;
            digits <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (score_valid) begin
                        sr   <= {16'b0, score_sat};
                        iter <= '0;
                    end
                end
                S_CONVERT: begin
                    sr   <= sr_step;
                    iter <= iter + CW'(1);
                end
                S_LOAD:  digits <= sr[SR_W-1:SCORE_W];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !game_over) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    logic [0:6] seg0, seg1, seg2, seg3;
    logic       lz1, lz2, lz3, all_off;

    hex7seg u_seg0 (.hex(digits[3:0]),   .display(seg0));
    hex7seg u_seg1 (.hex(digits[7:4]),   .display(seg1));
    hex7seg u_seg2 (.hex(digits[11:8]),  .display(seg2));
    hex7seg u_seg3 (.hex(digits[15:12]), .display(seg3));

    // Gating with game_over lets the digits return in the same cycle it drops.
    assign all_off = game_over & blink_off;
    assign lz3     = (LZ_BLANK != 0) && (digits[15:12] == 4'd0);
    assign lz2     = lz3 && (digits[11:8] == 4'd0);
    assign lz1     = lz2 && (digits[7:4] == 4'd0);

    assign HEX0 = all_off         ? SEG_BLANK : seg0;
    assign HEX1 = (all_off | lz1) ? SEG_BLANK : seg1;
    assign HEX2 = (all_off | lz2) ? SEG_BLANK : seg2;
    assign HEX3 = (all_off | lz3) ? SEG_BLANK : seg3;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with an expected-digits queue.
module tb_score_display_ctrl;

    localparam int SCORE_W   = 14;
    localparam int BLINK_DIV = 4;

    logic               clk;
    logic               reset;
    logic               score_valid;
    logic [SCORE_W-1:0] score;
    logic               ready;
    logic               game_over;
    logic [15:0]        digits;
    logic [0:6]         HEX0, HEX1, HEX2, HEX3;
    logic [1:0]         state_dbg;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] cur_digits;

    score_display_ctrl #(
        .SCORE_W  (SCORE_W),
        .BLINK_DIV(BLINK_DIV),
        .LZ_BLANK (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .score_valid(score_valid),
        .score      (score),
        .ready      (ready),
        .game_over  (game_over),
        .digits     (digits),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model
    function automatic logic [15:0] to_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] t [10];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        return (d < 4'd10) ? t[d] : 7'b1111111;
    endfunction

    function automatic logic [27:0] exp_hex(input logic [15:0] d, input logic off);
        logic [6:0] h [4];
        logic       lead;
        lead = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            if (off || (k > 0 && lead && d[k*4 +: 4] == 4'd0)) begin
                h[k] = 7'b1111111;
            end else begin
                h[k] = seg_of(d[k*4 +: 4]);
                lead = 1'b0;
            end
        end
        return {h[3], h[2], h[1], h[0]};
    endfunction

    // driver / checker tasks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int v, input bit push);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            n++;
            tick();
        end
        if (n >= 40)
            check("offer_timeout", 32'(ready), 32'd1);
        score       = SCORE_W'(v);
        score_valid = 1'b1;
        tick();
        if (push)
            exp_q.push_back(to_bcd(v));
        score_valid = 1'b0;
    endtask

    // Called right after the accepting edge; ends one edge after ready returns.
    task automatic expect_result(input string tag);
        int          low;
        bit          hold_ok;
        logic [15:0] prev;
        logic [15:0] exp_d;
        low     = 0;
        hold_ok = 1'b1;
        prev    = digits;
        while (ready === 1'b0 && low < 40) begin
            low++;
            if (digits !== prev)
                hold_ok = 1'b0;
            tick();
        end
        check({tag, "_ready_low"}, 32'(low), 32'(SCORE_W + 1));
        check({tag, "_hold"}, 32'(hold_ok), 32'd1);
        tick();
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            exp_d      = exp_q.pop_front();
            cur_digits = exp_d;
            check({tag, "_digits"}, 32'(digits), 32'(exp_d));
            check({tag, "_hex"}, 32'({HEX3, HEX2, HEX1, HEX0}), 32'(exp_hex(exp_d, 1'b0)));
        end
    endtask

    int scores [6] = '{1234, 7, 12000, 0, 1005, 16383};

    initial begin
        reset       = 1'b1;
        score_valid = 1'b0;
        score       = '0;
        game_over   = 1'b0;
        cur_digits  = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_ready", 32'(ready), 32'd1);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_hex", 32'({HEX3, HEX2, HEX1, HEX0}), 32'(exp_hex(16'h0, 1'b0)));

        foreach (scores[i]) begin
            offer(scores[i], 1'b1);
            check("convert_state", 32'(state_dbg), 32'd1);
            expect_result($sformatf("score%0d", scores[i]));
        end

        // busy handshake: 42 held valid throughout the 500 conversion
        score       = SCORE_W'(500);
        score_valid = 1'b1;
        tick();
        exp_q.push_back(to_bcd(500));
        score = SCORE_W'(42);
        expect_result("busy500");
        exp_q.push_back(to_bcd(42));
        score_valid = 1'b0;
        check("busy_second_accept", 32'(ready), 32'd0);
        expect_result("busy42");
        check("busy_final", 32'(digits), 32'h0042);

        // blink
        offer(1234, 1'b1);
        expect_result("blink_src");
        game_over = 1'b1;
        check("blink_start_on", 32'({HEX3, HEX2, HEX1, HEX0}), 32'(exp_hex(cur_digits, 1'b0)));
        for (int k = 1; k <= 13; k++) begin
            tick();
            check($sformatf("blink_k%0d", k), 32'({HEX3, HEX2, HEX1, HEX0}),
                  32'(exp_hex(cur_digits, ((k / BLINK_DIV) % 2) == 1)));
        end
        check("blink_digits", 32'(digits), 32'(cur_digits));
        check("blink_ready", 32'(ready), 32'd1);
        game_over = 1'b0;
        tick();
        check("blink_release", 32'({HEX3, HEX2, HEX1, HEX0}), 32'(exp_hex(cur_digits, 1'b0)));

        // reset during conversion
        reset = 1'b1;
        tick();
        reset = 1'b0;
        offer(8765, 1'b0);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_state", 32'(state_dbg), 32'd0);
        check("abort_digits", 32'(digits), 32'h0);
        repeat (20) tick();
        check("abort_digits_late", 32'(digits), 32'h0);
        check("abort_hex", 32'({HEX3, HEX2, HEX1, HEX0}), 32'(exp_hex(16'h0, 1'b0)));
        offer(8765, 1'b1);
        expect_result("after_abort");

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
